block_memory: RTL

Multi-cycle main-memory responder serving the data cache's miss traffic. Accepts single-word or 4-word burst read/write requests on the `readM`/`writeM`/`dataM`/`readyM` memory-side bus, waits a programmable access latency, then transfers data one word per cycle with `readyM` as the per-beat strobe. It sits at the memory end of the cache↔memory interface, and the cache is its only requester.

---
 rtl/block_memory.sv | 129 ++++++++++++
 1 files changed

// File: rtl/block_memory.sv
// Multi-cycle word memory answering cache miss traffic: single or 4-word wrapping bursts after a fixed latency.
// Optional request counters are compiled in with `define BLOCK_MEMORY_STATS_EN.
module block_memory #(
   parameter int WORD_SIZE = 16,
   parameter int ADDR_BITS = 8,
   parameter int LATENCY   = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 readM,
   input  logic                 writeM,
   input  logic                 blockM,
   input  logic [WORD_SIZE-1:0] address,
   inout  wire  [WORD_SIZE-1:0] dataM,
   output logic                 readyM
`ifdef BLOCK_MEMORY_STATS_EN
   ,
   output logic [15:0]          stat_reads,
   output logic [15:0]          stat_writes
`endif
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_XFER,
      S_RELEASE
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [3:0]           lat_cnt;
   logic [1:0]           beat_cnt;
   logic                 op_read;
   logic                 burst;
   logic [ADDR_BITS-1:0] beat_addr;
   logic                 drive;
   logic                 req_held;
   logic                 last_beat;
   logic                 accept;
   logic                 write_beat;
   logic                 unused_addr;

   logic [WORD_SIZE-1:0] mem [DEPTH];

   assign unused_addr = ^address[WORD_SIZE-1:ADDR_BITS];
   assign req_held    = op_read ? readM : writeM;
   assign last_beat   = !burst || (beat_cnt == 2'd3);
   assign accept      = (state == S_IDLE) && (readM || writeM);
   assign write_beat  = (state == S_XFER) && !op_read && writeM && reset_n;

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (readM || writeM) state_next = S_WAIT;
         S_WAIT: begin
            if (!req_held)             state_next = S_IDLE;
            else if (lat_cnt == 4'd0)  state_next = S_XFER;
         end
         S_XFER: begin
            if (!req_held)             state_next = S_IDLE;
            else if (last_beat)        state_next = S_RELEASE;
         end
         S_RELEASE: if (!readM && !writeM) state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // readyM and the bus enable are flops fed from the next state, so neither output glitches
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         readyM   <= 1'b0;
         drive    <= 1'b0;
         lat_cnt  <= 4'd0;
         beat_cnt <= 2'd0;
      end else begin
         state  <= state_next;
         readyM <= (state_next == S_XFER);
         drive  <= (state_next == S_XFER) && op_read;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  lat_cnt  <= 4'(LATENCY - 1);
                  beat_cnt <= 2'd0;
               end
            end
            S_WAIT:  if (lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
            S_XFER:  beat_cnt <= beat_cnt + 2'd1;
            default: ;
         endcase
      end
   end

   // Request fields; the beat address wraps inside the aligned 4-word block
   always_ff @(posedge clk) begin
      if (accept) begin
         op_read   <= readM;
         burst     <= blockM;
         beat_addr <= address[ADDR_BITS-1:0];
      end else if (state == S_XFER) begin
         beat_addr[1:0] <= beat_addr[1:0] + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (write_beat) mem[beat_addr] <= dataM;
   end

   assign dataM = drive ? mem[beat_addr] : {WORD_SIZE{1'bz}};

`ifdef BLOCK_MEMORY_STATS_EN
   logic done;
   assign done = (state == S_XFER) && req_held && last_beat;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stat_reads  <= 16'd0;
         stat_writes <= 16'd0;
      end else if (done) begin
         if (op_read && stat_reads != 16'hFFFF)   stat_reads  <= stat_reads + 16'd1;
         if (!op_read && stat_writes != 16'hFFFF) stat_writes <= stat_writes + 16'd1;
      end
   end
`endif

endmodule
